// File: rtl/alu_op_sequencer.sv
// Issue stage for the 16-bit ALU output controller: accepts an op, holds it for the settle time, captures the result with flags.
// Optional build macro ALU_SEQ_ACC_EN adds Use_Acc, which loads Operand_A from the last captured result.
module alu_op_sequencer #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned SETTLE_CYCLES = 2    // legal range 1..15
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             Op_Valid,
    output logic             Op_Ready,
    input  logic [1:0]       Op_Code,
    input  logic [WIDTH-1:0] A_In,
    input  logic [WIDTH-1:0] B_In,
`ifdef ALU_SEQ_ACC_EN
    input  logic             Use_Acc,
`endif
    output logic [1:0]       Control,
    output logic [WIDTH-1:0] Operand_A,
    output logic [WIDTH-1:0] Operand_B,
    input  logic [WIDTH-1:0] Result_In,
    output logic             Res_Valid,
    input  logic             Res_Ready,
    output logic [WIDTH-1:0] Result_Out,
    output logic             Flag_Z,
    output logic             Flag_N,
    output logic             Busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             capture;
    logic             retire;
    logic [WIDTH-1:0] op_a_src;

    // State register
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                if (capture) state_d = DONE;
            end
            DONE: begin
                if (accept)      state_d = EXEC;
                else if (retire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and datapath strobes decoded from the current state
    always_comb begin
        Op_Ready = 1'b0;
        Busy     = 1'b1;
        capture  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            IDLE: begin
                Op_Ready = 1'b1;
                Busy     = 1'b0;
            end
            EXEC: begin
                capture = (cnt_q == '0);
            end
            DONE: begin
                Op_Ready = Res_Ready;
                retire   = Res_Ready;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
        accept = Op_Valid & Op_Ready;
    end

`ifdef ALU_SEQ_ACC_EN
    // Result_Out still holds the retiring result on a same-edge accept from DONE
    assign op_a_src = Use_Acc ? Result_Out : A_In;
`else
    assign op_a_src = A_In;
`endif

    // Operation registers: loaded only on accept, held through EXEC and DONE
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Control   <= 2'b00;
            Operand_A <= '0;
            Operand_B <= '0;
        end else if (accept) begin
            Control   <= Op_Code;
            Operand_A <= op_a_src;
            Operand_B <= B_In;
        end
    end

    // Settle counter
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_LOAD;
        end else if (state_q == EXEC && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Result capture and output handshake
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Result_Out <= '0;
            Flag_Z     <= 1'b0;
            Flag_N     <= 1'b0;
            Res_Valid  <= 1'b0;
        end else if (capture) begin
            Result_Out <= Result_In;
            Flag_Z     <= ~|Result_In;
            Flag_N     <= Result_In[WIDTH-1];
            Res_Valid  <= 1'b1;
        end else if (retire) begin
            Res_Valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed spec cases plus randomized ops against a behavioural ALU model.
module tb_alu_op_sequencer;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned SETTLE = 2;

    logic              Clk = 1'b0;
    logic              nReset = 1'b0;
    logic              Op_Valid = 1'b0;
    logic              Op_Ready;
    logic [1:0]        Op_Code = 2'b00;
    logic [WIDTH-1:0]  A_In = '0;
    logic [WIDTH-1:0]  B_In = '0;
`ifdef ALU_SEQ_ACC_EN
    logic              Use_Acc = 1'b0;
`endif
    logic [1:0]        Control;
    logic [WIDTH-1:0]  Operand_A;
    logic [WIDTH-1:0]  Operand_B;
    logic [WIDTH-1:0]  Result_In;
    logic              Res_Valid;
    logic              Res_Ready = 1'b0;
    logic [WIDTH-1:0]  Result_Out;
    logic              Flag_Z;
    logic              Flag_N;
    logic              Busy;

    int                n_cmp = 0;
    int                n_fail = 0;
    int                n_acc_req = 0;
    logic [WIDTH-1:0]  last_res = '0;

    always #5 Clk = ~Clk;

    alu_op_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .Op_Valid   (Op_Valid),
        .Op_Ready   (Op_Ready),
        .Op_Code    (Op_Code),
        .A_In       (A_In),
        .B_In       (B_In),
`ifdef ALU_SEQ_ACC_EN
        .Use_Acc    (Use_Acc),
`endif
        .Control    (Control),
        .Operand_A  (Operand_A),
        .Operand_B  (Operand_B),
        .Result_In  (Result_In),
        .Res_Valid  (Res_Valid),
        .Res_Ready  (Res_Ready),
        .Result_Out (Result_Out),
        .Flag_Z     (Flag_Z),
        .Flag_N     (Flag_N),
        .Busy       (Busy)
    );

    function automatic logic [WIDTH-1:0] ref_alu(input logic [1:0] code,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (code)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a + b;
            default: return a - b;
        endcase
    endfunction

    // ALU units plus output controller, driven by the sequencer's registered outputs
    always_comb Result_In = ref_alu(Control, Operand_A, Operand_B);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an op at a negedge and check the registered copy after the accept edge
    task automatic issue(input logic [1:0] code, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic acc,
                         output logic [WIDTH-1:0] er);
        logic [WIDTH-1:0] ea;
        ea = a;
        if (acc) n_acc_req++;
`ifdef ALU_SEQ_ACC_EN
        if (acc) ea = last_res;
        Use_Acc = acc;
`endif
        er = ref_alu(code, ea, b);
        chk("op_ready_idle", 32'(Op_Ready), 32'd1);
        Op_Valid = 1'b1; Op_Code = code; A_In = a; B_In = b;
        @(negedge Clk);
        Op_Valid = 1'b0;
        Op_Code = 2'($urandom); A_In = WIDTH'($urandom); B_In = WIDTH'($urandom);
`ifdef ALU_SEQ_ACC_EN
        Use_Acc = 1'($urandom);
`endif
        chk("control", 32'(Control), 32'(code));
        chk("operand_a", 32'(Operand_A), 32'(ea));
        chk("operand_b", 32'(Operand_B), 32'(b));
        chk("busy_exec", 32'(Busy), 32'd1);
        chk("op_ready_exec", 32'(Op_Ready), 32'd0);
    endtask

    // Count edges from accept to Res_Valid, then check the captured result and flags
    task automatic wait_result(input logic [WIDTH-1:0] er);
        int n;
        n = 0;
        while (Res_Valid !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("latency", 32'(n), 32'(SETTLE));
        chk("result", 32'(Result_Out), 32'(er));
        chk("flag_z", 32'(Flag_Z), 32'(er == '0));
        chk("flag_n", 32'(Flag_N), 32'(er[WIDTH-1]));
    endtask

    // Hold Res_Ready low for 'hold' cycles (pulsing a stray op), then retire to IDLE
    task automatic retire(input logic [1:0] code, input logic [WIDTH-1:0] er, input int hold);
        logic [1:0] ctl;
        ctl = Control;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                Op_Valid = 1'b1; Op_Code = ~code; A_In = WIDTH'($urandom);
            end
            @(negedge Clk);
            Op_Valid = 1'b0;
            chk("bp_valid", 32'(Res_Valid), 32'd1);
            chk("bp_result", 32'(Result_Out), 32'(er));
            chk("bp_flag_z", 32'(Flag_Z), 32'(er == '0));
            chk("bp_control", 32'(Control), 32'(ctl));
            chk("bp_op_ready", 32'(Op_Ready), 32'd0);
        end
        Res_Ready = 1'b1;
        @(negedge Clk);
        Res_Ready = 1'b0;
        chk("retire_valid", 32'(Res_Valid), 32'd0);
        chk("retire_busy", 32'(Busy), 32'd0);
        chk("retire_hold", 32'(Result_Out), 32'(er));
        last_res = er;
    endtask

    task automatic do_op(input logic [1:0] code, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic acc, input int hold);
        logic [WIDTH-1:0] er;
        @(negedge Clk);
        issue(code, a, b, acc, er);
        wait_result(er);
        retire(code, er, hold);
    endtask

    initial begin
        logic [WIDTH-1:0] er1;
        logic [WIDTH-1:0] er2;
        int               seen;

        // Reset state
        #12;
        chk("rst_op_ready", 32'(Op_Ready), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_res_valid", 32'(Res_Valid), 32'd0);
        chk("rst_control", 32'(Control), 32'd0);
        chk("rst_operand_a", 32'(Operand_A), 32'd0);
        chk("rst_result", 32'(Result_Out), 32'd0);
        chk("rst_flags", 32'({Flag_Z, Flag_N}), 32'd0);
        @(negedge Clk);
        nReset = 1'b1;

        // Directed cases
        do_op(2'b10, 16'h1234, 16'h0001, 1'b0, 0);
        do_op(2'b11, 16'h00FF, 16'h00FF, 1'b0, 0);
        do_op(2'b00, 16'hF0F0, 16'h8F00, 1'b0, 0);
        do_op(2'b01, 16'h00F0, 16'h000F, 1'b0, 5);

        // Back-to-back: new op accepted on the retire edge
        @(negedge Clk);
        issue(2'b10, 16'h7FFF, 16'h0001, 1'b0, er1);
        wait_result(er1);
        er2 = ref_alu(2'b01, 16'h0A0A, 16'h5050);
        Res_Ready = 1'b1; Op_Valid = 1'b1; Op_Code = 2'b01; A_In = 16'h0A0A; B_In = 16'h5050;
        @(negedge Clk);
        Res_Ready = 1'b0; Op_Valid = 1'b0;
        chk("b2b_valid", 32'(Res_Valid), 32'd0);
        chk("b2b_busy", 32'(Busy), 32'd1);
        chk("b2b_control", 32'(Control), 32'd1);
        chk("b2b_operand_a", 32'(Operand_A), 32'h0A0A);
        wait_result(er2);
        retire(2'b01, er2, 0);

        // Reset one cycle after accept drops the op
        @(negedge Clk);
        issue(2'b10, 16'h1111, 16'h2222, 1'b0, er1);
        nReset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(Res_Valid), 32'd0);
        chk("mid_rst_control", 32'(Control), 32'd0);
        chk("mid_rst_operand_a", 32'(Operand_A), 32'd0);
        chk("mid_rst_op_ready", 32'(Op_Ready), 32'd1);
        @(negedge Clk);
        nReset = 1'b1;
        last_res = '0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (Res_Valid === 1'b1) seen++;
        end
        chk("mid_rst_no_result", 32'(seen), 32'd0);

`ifdef ALU_SEQ_ACC_EN
        do_op(2'b10, 16'h0005, 16'h0003, 1'b0, 0);
        do_op(2'b11, 16'hDEAD, 16'h0008, 1'b1, 0);
`endif

        // Randomized ops
        for (int k = 0; k < 40; k++) begin
            logic [1:0]       c;
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            c = 2'($urandom_range(0, 3));
            a = WIDTH'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom);
            do_op(c, a, b, 1'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
